// File: rtl/alu8_pkg.sv
// Shared widths, func encodings and CMOS-style gate helpers for the ALU datapath.
package alu8_pkg;
  localparam int DATA_W    = 8;
  localparam int RADDR_W   = 4;
  localparam int MADDR_W   = 8;
  localparam int FUNC_W    = 3;
  localparam int NREGS     = 16;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [FUNC_W-1:0] {
    F_ADD   = 3'b000,
    F_SUB   = 3'b001,
    F_AND   = 3'b010,
    F_OR    = 3'b011,
    F_XOR   = 3'b100,
    F_NOT_A = 3'b101,
    F_NOT_B = 3'b110,
    F_INC_A = 3'b111
  } func_e;

  // Static CMOS primitives.
  // inv  : one pmos pull-up and one nmos pull-down.
  // nand : parallel pmos, series nmos.
  // nor  : series pmos, parallel nmos.
  // Modelled by their logic function so the datapath stays single-driver.
  function automatic logic inv1(input logic x);
    return ~x;
  endfunction

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  // Classic four-NAND XOR.
  function automatic logic xor2(input logic x, input logic y);
    logic n;
    n = nand2(x, y);
    return nand2(nand2(x, n), nand2(y, n));
  endfunction
endpackage

// File: rtl/alu8_core.sv
// Combinational 8-bit datapath.
// One shared ripple adder serves ADD, SUB (A + ~B + 1) and INC_A (A + 0 + 1).
module alu8_core
  import alu8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FUNC_W-1:0] func,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] result,
  output logic              flag
);
  logic [DATA_W-1:0] sum, and_v, or_v, xor_v, nota_v, notb_v;
  logic              cout;

  // Gate-level ripple adder and bitwise logic, one bit cell per iteration.
  always_comb begin
    logic sub_op, inc_op, cy, bi, pi;
    sum    = '0;
    and_v  = '0;
    or_v   = '0;
    xor_v  = '0;
    nota_v = '0;
    notb_v = '0;
    sub_op = (func == F_SUB);
    inc_op = (func == F_INC_A);
    cy     = sub_op | inc_op;
    bi     = 1'b0;
    pi     = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      bi        = inc_op ? 1'b0 : (sub_op ? inv1(b[i]) : b[i]);
      pi        = xor2(a[i], bi);
      sum[i]    = xor2(pi, cy);
      cy        = nand2(nand2(a[i], bi), nand2(pi, cy));
      and_v[i]  = inv1(nand2(a[i], b[i]));
      or_v[i]   = inv1(nor2(a[i], b[i]));
      xor_v[i]  = xor2(a[i], b[i]);
      nota_v[i] = inv1(a[i]);
      notb_v[i] = inv1(b[i]);
    end
    cout = cy;
  end

  // Result select: load wins, and only the arithmetic ops carry a flag.
  always_comb begin
    result = '0;
    flag   = 1'b0;
    if (load) begin
      result = load_data;
    end else begin
      case (func)
        F_ADD, F_SUB, F_INC_A: begin result = sum; flag = cout; end
        F_AND:   result = and_v;
        F_OR:    result = or_v;
        F_XOR:   result = xor_v;
        F_NOT_A: result = nota_v;
        F_NOT_B: result = notb_v;
        default: result = '0;
      endcase
    end
  end
endmodule

// File: rtl/nmos_pmos_alu8.sv
// Four-stage ALU pipeline: issue, execute, writeback, store.
// Holds the register bank and the result memory; no forwarding, no interlock.
module nmos_pmos_alu8
  import alu8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] addr1,
  input  logic [RADDR_W-1:0] addr2,
  input  logic [RADDR_W-1:0] rd,
  input  logic [FUNC_W-1:0]  func,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               write,
  input  logic [MADDR_W-1:0] memaddr,
  input  logic [MADDR_W-1:0] mem_rdaddr,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  Zout,
  output logic               carry_borrow
);
  logic [DATA_W-1:0]  regs [NREGS];
  logic [DATA_W-1:0]  mem  [MEM_DEPTH];

  // vld_pipe[0]: stage-1 valid, [1]: stage-2 valid, [2]: stage-3 valid.
  logic [2:0]         vld_pipe;

  logic [DATA_W-1:0]  s1_a, s1_b, s1_ld;
  logic [RADDR_W-1:0] s1_rd;
  logic [FUNC_W-1:0]  s1_func;
  logic               s1_load, s1_write;
  logic [MADDR_W-1:0] s1_ma;

  logic [DATA_W-1:0]  s2_res;
  logic               s2_flag, s2_write;
  logic [RADDR_W-1:0] s2_rd;
  logic [MADDR_W-1:0] s2_ma;

  logic               s3_write;
  logic [MADDR_W-1:0] s3_ma;

  logic [DATA_W-1:0]  ex_res;
  logic               ex_flag;

  alu8_core u_core (
    .a         (s1_a),
    .b         (s1_b),
    .func      (s1_func),
    .load      (s1_load),
    .load_data (s1_ld),
    .result    (ex_res),
    .flag      (ex_flag)
  );

  // Pipeline registers; reset discards every in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_ld        <= '0;
      s1_rd        <= '0;
      s1_func      <= '0;
      s1_load      <= 1'b0;
      s1_write     <= 1'b0;
      s1_ma        <= '0;
      s2_res       <= '0;
      s2_flag      <= 1'b0;
      s2_write     <= 1'b0;
      s2_rd        <= '0;
      s2_ma        <= '0;
      Zout         <= '0;
      carry_borrow <= 1'b0;
      s3_write     <= 1'b0;
      s3_ma        <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[1:0], 1'b1};
      // Operand reads see the bank before this edge's writeback.
      s1_a         <= regs[addr1];
      s1_b         <= regs[addr2];
      s1_ld        <= load_data;
      s1_rd        <= rd;
      s1_func      <= func;
      s1_load      <= load;
      s1_write     <= write;
      s1_ma        <= memaddr;
      s2_res       <= ex_res;
      s2_flag      <= ex_flag;
      s2_write     <= s1_write;
      s2_rd        <= s1_rd;
      s2_ma        <= s1_ma;
      Zout         <= s2_res;
      carry_borrow <= s2_flag;
      s3_write     <= s2_write;
      s3_ma        <= s2_ma;
    end
  end

  // Register bank writeback from stage 2 into the bank at the stage-3 edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (vld_pipe[1]) begin
      regs[s2_rd] <= s2_res;
    end
  end

  // Result memory store; contents survive reset.
  always_ff @(posedge clk) begin
    if (vld_pipe[2] && s3_write) mem[s3_ma] <= Zout;
  end

  assign mem_rdata = mem[mem_rdaddr];
endmodule

// File: tb/tb_nmos_pmos_alu8.sv
// Bench for nmos_pmos_alu8: directed table, hand-written hazard/reset/memory
// sequences and random traffic against an instruction-level reference model.
module tb_nmos_pmos_alu8;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr1, addr2, rd;
  logic [2:0] func;
  logic       load, write;
  logic [7:0] load_data, memaddr, mem_rdaddr, mem_rdata, Zout;
  logic       carry_borrow;

  always #5 clk = ~clk;

  nmos_pmos_alu8 dut (
    .clk(clk), .rst(rst), .addr1(addr1), .addr2(addr2), .rd(rd), .func(func),
    .load(load), .load_data(load_data), .write(write), .memaddr(memaddr),
    .mem_rdaddr(mem_rdaddr), .mem_rdata(mem_rdata), .Zout(Zout),
    .carry_borrow(carry_borrow)
  );

  typedef struct {
    logic [3:0] a1, a2, rd;
    logic [2:0] fn;
    logic       ld;
    logic [7:0] ldd;
    logic       wr;
    logic [7:0] ma;
  } ins_t;

  typedef struct {
    ins_t       i;
    logic [7:0] ez;
    logic       ef;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       fl;
    logic [3:0] rd;
    logic       wr;
    logic [7:0] ma;
  } inf_t;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] m_reg [16];
  logic [7:0] m_mem [256];
  inf_t       q [$];
  vec_t       tbl [15];
  logic [7:0] save81;

  function automatic ins_t mk(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] r,
                              input logic [2:0] fn, input logic ld, input logic [7:0] ldd,
                              input logic wr, input logic [7:0] ma);
    ins_t x;
    x.a1 = a1; x.a2 = a2; x.rd = r; x.fn = fn; x.ld = ld; x.ldd = ldd; x.wr = wr; x.ma = ma;
    return x;
  endfunction

  function automatic vec_t mkv(input ins_t i, input logic [7:0] ez, input logic ef);
    vec_t v;
    v.i = i; v.ez = ez; v.ef = ef;
    return v;
  endfunction

  // Reference ALU from the arithmetic definitions: {flag, result}.
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] fn, input logic ld,
                                         input logic [7:0] ldd);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (ld) return {1'b0, ldd};
    case (fn)
      3'd0: return {sa + sb > 255, 8'(sa + sb)};
      3'd1: return {sa >= sb, 8'(sa - sb)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, ~b};
      default: return {sa == 255, 8'(sa + 1)};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one instruction, advance the model one edge, compare outputs.
  task automatic step(input ins_t v);
    inf_t       e, wb, st;
    logic [8:0] r;
    logic [7:0] ez;
    logic       ef, do_mem;
    addr1 = v.a1; addr2 = v.a2; rd = v.rd; func = v.fn; load = v.ld;
    load_data = v.ldd; write = v.wr; memaddr = v.ma;
    @(posedge clk);
    r = ref_alu(m_reg[v.a1], m_reg[v.a2], v.fn, v.ld, v.ldd);
    e.res = r[7:0]; e.fl = r[8]; e.rd = v.rd; e.wr = v.wr; e.ma = v.ma;
    q.push_back(e);
    if (q.size() > 4) void'(q.pop_front());
    ez = 8'h00; ef = 1'b0; do_mem = 1'b0;
    if (q.size() >= 3) begin
      wb = q[q.size()-3];
      m_reg[wb.rd] = wb.res;
      ez = wb.res; ef = wb.fl;
    end
    if (q.size() >= 4) begin
      st = q[0];
      if (st.wr) begin
        m_mem[st.ma] = st.res;
        mem_rdaddr = st.ma;
        do_mem = 1'b1;
      end
    end
    #1;
    chk("zout_model", Zout, ez);
    chk("flag_model", {7'b0, carry_borrow}, {7'b0, ef});
    if (do_mem) chk("mem_model", mem_rdata, m_mem[mem_rdaddr]);
  endtask

  task automatic idle();
    step(mk(4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_reg[k] = 8'h00;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    addr1 = 0; addr2 = 0; rd = 0; func = 0; load = 0; load_data = 0;
    write = 0; memaddr = 0; mem_rdaddr = 0;
    model_reset();
    for (int k = 0; k < 256; k++) m_mem[k] = 8'h00;

    tbl[0]  = mkv(mk(0, 0, 1, 3'd0, 1, 8'h3C, 0, 0), 8'h3C, 0);
    tbl[1]  = mkv(mk(0, 0, 2, 3'd0, 1, 8'h0F, 0, 0), 8'h0F, 0);
    tbl[2]  = mkv(mk(1, 2, 3, 3'd0, 0, 8'h00, 0, 0), 8'h4B, 0);
    tbl[3]  = mkv(mk(1, 2, 9, 3'd1, 0, 8'h00, 0, 0), 8'h2D, 1);
    tbl[4]  = mkv(mk(2, 1, 9, 3'd1, 0, 8'h00, 0, 0), 8'hD3, 0);
    tbl[5]  = mkv(mk(0, 0, 4, 3'd1, 1, 8'hFF, 0, 0), 8'hFF, 0);
    tbl[6]  = mkv(mk(0, 0, 5, 3'd7, 1, 8'h01, 0, 0), 8'h01, 0);
    tbl[7]  = mkv(mk(4, 5, 9, 3'd0, 0, 8'h00, 0, 0), 8'h00, 1);
    tbl[8]  = mkv(mk(4, 0, 9, 3'd7, 0, 8'h00, 0, 0), 8'h00, 1);
    tbl[9]  = mkv(mk(5, 0, 9, 3'd7, 0, 8'h00, 0, 0), 8'h02, 0);
    tbl[10] = mkv(mk(1, 2, 9, 3'd2, 0, 8'h00, 0, 0), 8'h0C, 0);
    tbl[11] = mkv(mk(1, 2, 9, 3'd3, 0, 8'h00, 0, 0), 8'h3F, 0);
    tbl[12] = mkv(mk(1, 2, 9, 3'd4, 0, 8'h00, 0, 0), 8'h33, 0);
    tbl[13] = mkv(mk(1, 2, 9, 3'd5, 0, 8'h00, 0, 0), 8'hC3, 0);
    tbl[14] = mkv(mk(1, 2, 9, 3'd6, 0, 8'h00, 0, 0), 8'hF0, 0);

    // Reset state.
    #12;
    chk("reset_zout", Zout, 8'h00);
    chk("reset_flag", {7'b0, carry_borrow}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, three cycles apart so each sees prior results.
    for (int k = 0; k < 15; k++) begin
      step(tbl[k].i);
      idle();
      idle();
      chk($sformatf("vec%0d_zout", k), Zout, tbl[k].ez);
      chk($sformatf("vec%0d_flag", k), {7'b0, carry_borrow}, {7'b0, tbl[k].ef});
    end

    // Memory store and non-store.
    mem_rdaddr = 8'h81;
    #1 save81 = mem_rdata;
    step(mk(1, 2, 3, 3'd0, 0, 8'h00, 1, 8'h80));
    idle();
    idle();
    chk("mem_zout", Zout, 8'h4B);
    idle();
    mem_rdaddr = 8'h80;
    #1 chk("mem_store_80", mem_rdata, 8'h4B);
    step(mk(1, 2, 3, 3'd0, 0, 8'h00, 0, 8'h81));
    idle(); idle(); idle();
    mem_rdaddr = 8'h81;
    #1 chk("mem_nostore_81", mem_rdata, save81);

    // Back-to-back stores to one address, then reset kills a pending store.
    step(mk(1, 0, 10, 3'd0, 0, 8'h00, 1, 8'h90));
    step(mk(2, 0, 10, 3'd0, 0, 8'h00, 1, 8'h90));
    idle(); idle(); idle();
    mem_rdaddr = 8'h90;
    #1 chk("later_store_wins", mem_rdata, 8'h0F);
    step(mk(1, 2, 10, 3'd4, 0, 8'h00, 1, 8'h90));
    idle();
    idle();
    chk("pre_reset_zout", Zout, 8'h33);
    #2 rst = 1'b1;
    #1;
    chk("midreset_zout", Zout, 8'h00);
    chk("midreset_flag", {7'b0, carry_borrow}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_rdaddr = 8'h90;
    #1 chk("reset_drops_store", mem_rdata, 8'h0F);
    step(mk(1, 2, 3, 3'd0, 0, 8'h00, 0, 8'h00));
    idle();
    idle();
    chk("post_reset_add", Zout, 8'h00);
    idle();
    mem_rdaddr = 8'h90;
    #1 chk("reset_drops_store2", mem_rdata, 8'h0F);

    // Read-after-write hazard: stale at N+1, fresh at N+3.
    step(mk(0, 0, 6, 3'd0, 1, 8'h11, 0, 8'h00));
    step(mk(6, 0, 7, 3'd7, 0, 8'h00, 0, 8'h00));
    idle();
    step(mk(6, 0, 8, 3'd7, 0, 8'h00, 0, 8'h00));
    chk("hazard_stale", Zout, 8'h01);
    idle();
    idle();
    chk("hazard_fresh", Zout, 8'h12);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, 3) == 0, 8'h A0 + 8'($urandom_range(0, 15))));
    end
    idle(); idle(); idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nmos_pmos_alu8.md
# nmos_pmos_alu8

Four-stage pipelined 8-bit ALU with a 16×8 register bank and a 256×8 result memory, clocked by a single clock. The datapath is built from CMOS switch-level gates (`nmos`/`pmos` pull-up/pull-down networks), and every result must match the behavioural arithmetic below. It sits as the compute engine of the CMOS datapath. Each cycle it issues one register-to-register operation; the result is written back to the register bank and optionally to memory.

## Interface
- No parameters. Widths are fixed: data 8, register address 4, memory address 8, func 3.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `addr1` in 4: register index of operand A.
- `addr2` in 4: register index of operand B.
- `rd` in 4: destination register index.
- `func` in 3: operation code.
- `load` in 1: when 1, the result is `load_data` instead of the ALU output.
- `load_data` in 8: immediate value used by a load.
- `write` in 1: when 1, the result is also stored to memory.
- `memaddr` in 8: memory address for the store.
- `mem_rdaddr` in 8: memory read address, used for verification.
- `mem_rdata` out 8: combinational `mem[mem_rdaddr]`.
- `Zout` out 8: registered result of the stage-3 instruction.
- `carry_borrow` out 1: registered carry flag accompanying `Zout`.

## Operation
- Func encodings:
  - ADD=000: A+B; flag = carry-out.
  - SUB=001: A+~B+1, mod 256; flag = carry-out, so 1 iff A≥B unsigned.
  - AND=010
  - OR=011
  - XOR=100
  - NOT_A=101
  - NOT_B=110
  - INC_A=111: A+1; flag = carry-out, so 1 iff A=0xFF.
- Logic ops and NOT ops force the flag to 0.
- `load`=1 overrides `func`: result = `load_data`, flag = 0.
- Stage 1 (issue): latch A=`regbank[addr1]`, B=`regbank[addr2]`, plus `rd`, `func`, `load`, `load_data`, `write`, `memaddr`.
- Stage 2 (execute): compute result and flag; carry `rd`, `write`, `memaddr` forward.
- Stage 3 (writeback): `regbank[rd]` ← result; `Zout`/`carry_borrow` ← result/flag; `write`/`memaddr` forward.
- Stage 4 (store): if `write`, `mem[memaddr]` ← result. Otherwise memory is unchanged.
- No forwarding and no interlock.
- Register reads see the register-bank contents before the current edge's writeback.
- Register 0 is an ordinary writable register.

## Timing
- Reset (asynchronous, any time, including mid-pipeline):
  - all pipeline registers, `Zout`, `carry_borrow` and all 16 registers → 0;
  - all valid/write flags cleared, so in-flight instructions are discarded and no memory write occurs.
- Memory contents are not reset.
- After reset deasserts, the pipeline holds func=ADD on r0,r0 into r0, which produces 0; there are no side effects until issue.
- Instruction sampled at edge N:
  - result on `Zout` after edge N+2;
  - register bank updated at edge N+2;
  - memory updated at edge N+3, readable on `mem_rdata` immediately after.
- Read-after-write: a dependent instruction must be sampled at edge ≥ N+3.
  - At N+1 or N+2 it reads the stale value. This is required behaviour, not an error.
- Simultaneous stage-1 read and stage-3 write of the same register: the read returns the old value.
- Two stores to the same address in consecutive cycles: the later instruction wins.
- Throughput is one instruction per cycle.

## Structure
- Shared package `alu8_pkg`: func encoding constants (ADD…INC_A) and the width constants.
- One natural sub-module, `alu8_core`: the combinational datapath.
  - Inputs: A, B, func, load, load_data.
  - Outputs: result, flag.
  - Built from the switch-level inverter/NAND/NOR gates, ripple adder and subtractor.
- Top level holds the pipeline registers, register bank and memory.

## Test plan
- Reset: pulse `rst` mid-stream → `Zout`=0x00 and `carry_borrow`=0 immediately; a later ADD r1,r2 yields 0x00; a pending `write` does not store.
- Loads and arithmetic (issue each load 3 cycles apart):
  - load r1=0x3C, r2=0x0F;
  - ADD r1,r2→r3 → `Zout`=0x4B, flag 0, two edges after issue;
  - SUB r1,r2 → 0x2D, flag 1;
  - SUB r2,r1 → 0xD3, flag 0.
- Overflow: r4=0xFF, r5=0x01:
  - ADD r4,r5 → 0x00, flag 1;
  - INC_A r4 → 0x00, flag 1;
  - INC_A r5 → 0x02, flag 0.
- Logic on r1=0x3C, r2=0x0F: AND → 0x0C, OR → 0x3F, XOR → 0x33, NOT_A → 0xC3, NOT_B → 0xF0, all with flag 0.
- Memory: ADD with `write`=1, `memaddr`=0x80 → `mem_rdata`@0x80 = 0x4B one cycle after `Zout`; same op with `write`=0 to 0x81 → 0x81 unchanged.
- Hazard: load r6=0x11 at edge N, then INC_A r6 at N+1 → 0x01 (stale 0); at N+3 → 0x12.
